// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32 execute stage: ALU, data-memory request FSM, EX->MEM and forwarding buses; EX_MUL_EN adds an iterative multiplier
module ex_stage #(
  parameter int ID_TO_EX_BUS_WD  = 143,
  parameter int EX_TO_MEM_BUS_WD = 108,
  parameter int RDW_BUS_WD       = 39
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MEM_Allow_in,
  output logic                        EX_Allow_in,
  input  logic                        ID_to_EX_Valid,
  input  logic [ID_TO_EX_BUS_WD-1:0]  ID_to_EX_Bus,
  output logic                        EX_to_MEM_Valid,
  output logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_Bus,
  output logic [31:0]                 Address,
  output logic                        MemRead,
  output logic                        MemWrite,
  output logic [31:0]                 Write_data,
  output logic [3:0]                  Write_strb,
  input  logic                        Mem_Req_Ready,
  output logic [RDW_BUS_WD-1:0]       rdw_EX_Bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} mem_state_t;

  logic                       ex_valid;
  logic                       ex_ready;
  logic [ID_TO_EX_BUS_WD-1:0] bus_r;
  mem_state_t                 state_q, state_d;
  logic                       mem_rd, mem_wr;
  logic [31:0]                alu_res, result;
  logic                       mul_stall;

  logic [31:0] pc, op_a, op_b, rf_rdata2;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic        load, store, wb_wen;
  logic [4:0]  rf_waddr;
  logic [1:0]  off;

  assign pc        = bus_r[142:111];
  assign op_a      = bus_r[110:79];
  assign op_b      = bus_r[78:47];
  assign rf_rdata2 = bus_r[46:15];
  assign alu_op    = bus_r[14:11];
  assign funct3    = bus_r[10:8];
  assign load      = bus_r[7];
  assign store     = bus_r[6];
  assign wb_wen    = bus_r[5];
  assign rf_waddr  = bus_r[4:0];

  // EX occupancy: follows ID valid whenever EX can take a new instruction
  always_ff @(posedge clk) begin
    if (rst)              ex_valid <= 1'b0;
    else if (EX_Allow_in) ex_valid <= ID_to_EX_Valid;
  end

  // Instruction payload register, deliberately left unreset
  always_ff @(posedge clk) begin
    if (ID_to_EX_Valid && EX_Allow_in) bus_r <= ID_to_EX_Bus;
  end

  // Single-cycle ALU; unused opcodes (and 11 without the multiplier) add
  always_comb begin
    alu_res = op_a + op_b;
    case (alu_op)
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << op_b[4:0];
      4'd3:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {31'b0, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> op_b[4:0];
      4'd7:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

`ifdef EX_MUL_EN
  logic        mul_busy, mul_done;
  logic [4:0]  mul_cnt;
  logic [31:0] mul_acc;
  logic        is_mul;

  assign is_mul = (alu_op == 4'd11);

  // Shift-add multiplier: one multiplier bit per cycle, armed on entry, holds until the next entry
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_busy <= 1'b0;
      mul_done <= 1'b0;
      mul_cnt  <= 5'd0;
      mul_acc  <= 32'd0;
    end else if (EX_Allow_in) begin
      mul_busy <= ID_to_EX_Valid && (ID_to_EX_Bus[14:11] == 4'd11);
      mul_done <= 1'b0;
      mul_cnt  <= 5'd0;
      mul_acc  <= 32'd0;
    end else if (mul_busy) begin
      if (op_b[mul_cnt]) mul_acc <= mul_acc + (op_a << mul_cnt);
      mul_cnt <= mul_cnt + 5'd1;
      if (mul_cnt == 5'd31) begin
        mul_busy <= 1'b0;
        mul_done <= 1'b1;
      end
    end
  end

  assign mul_stall = ex_valid & is_mul & ~mul_done;
  assign result    = is_mul ? mul_acc : alu_res;
`else
  assign mul_stall = 1'b0;
  assign result    = alu_res;
`endif

  // Memory request FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // One request per load/store; readiness comes from acceptance or the multiplier
  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ex_ready = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (load || store) begin
          ex_ready = 1'b0;
          if (ex_valid && MEM_Allow_in) state_d = S_REQ;
        end else begin
          ex_ready = ~mul_stall;
        end
      end
      S_REQ: begin
        mem_rd   = load;
        mem_wr   = store;
        ex_ready = Mem_Req_Ready;
        if (Mem_Req_Ready) state_d = MEM_Allow_in ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (MEM_Allow_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Store lane alignment from the low address bits
  always_comb begin
    Write_data = rf_rdata2 << {off, 3'b000};
    case (funct3[1:0])
      2'b00:   Write_strb = 4'b0001 << off;
      2'b01:   Write_strb = 4'b0011 << off;
      default: Write_strb = 4'b1111;
    endcase
  end

  assign off             = result[1:0];
  assign Address         = {result[31:2], 2'b00};
  assign MemRead         = mem_rd & ~rst;
  assign MemWrite        = mem_wr & ~rst;
  assign EX_Allow_in     = ~ex_valid | (ex_ready & MEM_Allow_in);
  assign EX_to_MEM_Valid = ex_valid & ex_ready & ~rst;
  assign EX_to_MEM_Bus   = {rf_rdata2, result, funct3, load, store, store, wb_wen, rf_waddr, pc};
  assign rdw_EX_Bus      = {ex_ready, wb_wen & ex_valid & ~rst, rf_waddr, result};

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - vector table, hand sequences and randomized model check for ex_stage; EX_MUL_EN enables the multiplier test
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         MEM_Allow_in;
  logic         EX_Allow_in;
  logic         ID_to_EX_Valid;
  logic [142:0] ID_to_EX_Bus;
  logic         EX_to_MEM_Valid;
  logic [107:0] EX_to_MEM_Bus;
  logic [31:0]  Address;
  logic         MemRead;
  logic         MemWrite;
  logic [31:0]  Write_data;
  logic [3:0]   Write_strb;
  logic         Mem_Req_Ready;
  logic [38:0]  rdw_EX_Bus;

  int n_vec = 0;
  int n_bad = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .MEM_Allow_in(MEM_Allow_in), .EX_Allow_in(EX_Allow_in),
    .ID_to_EX_Valid(ID_to_EX_Valid), .ID_to_EX_Bus(ID_to_EX_Bus),
    .EX_to_MEM_Valid(EX_to_MEM_Valid), .EX_to_MEM_Bus(EX_to_MEM_Bus),
    .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .Mem_Req_Ready(Mem_Req_Ready), .rdw_EX_Bus(rdw_EX_Bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vt[14];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [142:0] mk_bus(input logic [31:0] pc, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] rd2,
                                          input logic [3:0] op, input logic [2:0] f3,
                                          input logic ld, input logic st, input logic wen,
                                          input logic [4:0] wa);
    return {pc, a, b, rd2, op, f3, ld, st, wen, wa};
  endfunction

  // Reference ALU written with plain arithmetic
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p2;
    int          sa, sb;
    p2 = 32'd1 << b[4:0];
    sa = a;
    sb = b;
    case (op)
      4'd1:  return a - b;
      4'd2:  return a * p2;
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a / p2;
      4'd7:  return a[31] ? ~((~a) / p2) : a / p2;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return a + b;
    endcase
  endfunction

  logic        occ, exp_allow;
  logic [31:0] m_res, m_pc;
  logic [4:0]  m_wa;
  logic        m_wen;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b, r_pc;
  logic [4:0]  r_wa;
  logic        r_wen;
  logic [3:0]  strb_q[$];
  logic [31:0] data_q[$];
  logic        accepted;
  int          stalls;

  initial begin
    vt[0]  = '{4'd0,  32'd5,        32'hFFFFFFFE, 32'd3};
    vt[1]  = '{4'd1,  32'd3,        32'd5,        32'hFFFFFFFE};
    vt[2]  = '{4'd2,  32'd1,        32'h0000003F, 32'h80000000};
    vt[3]  = '{4'd3,  32'hFFFFFFFF, 32'd1,        32'd1};
    vt[4]  = '{4'd4,  32'hFFFFFFFF, 32'd1,        32'd0};
    vt[5]  = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vt[6]  = '{4'd6,  32'h80000000, 32'd4,        32'h08000000};
    vt[7]  = '{4'd7,  32'h80000000, 32'd4,        32'hF8000000};
    vt[8]  = '{4'd8,  32'h00000F00, 32'h000000F0, 32'h00000FF0};
    vt[9]  = '{4'd9,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    vt[10] = '{4'd10, 32'd1,        32'h12345678, 32'h12345678};
`ifdef EX_MUL_EN
    vt[11] = '{4'd0,  32'd7,        32'd8,        32'h0000000F};
`else
    vt[11] = '{4'd11, 32'd7,        32'd8,        32'h0000000F};
`endif
    vt[12] = '{4'd15, 32'd10,       32'd20,       32'h0000001E};
    vt[13] = '{4'd0,  32'hFFFFFFFF, 32'd1,        32'd0};

    rst = 1'b1; ID_to_EX_Valid = 1'b0; ID_to_EX_Bus = '0;
    MEM_Allow_in = 1'b1; Mem_Req_Ready = 1'b0;
    cyc(); cyc();
    chk("reset_out_valid", 32'(EX_to_MEM_Valid), 32'd0);
    chk("reset_memread", 32'(MemRead), 32'd0);
    chk("reset_memwrite", 32'(MemWrite), 32'd0);
    chk("reset_rdw_valid", 32'(rdw_EX_Bus[37]), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_allow", 32'(EX_Allow_in), 32'd1);

    // ALU table: one instruction in, checked the cycle after entry
    for (int i = 0; i < 14; i++) begin
      ID_to_EX_Bus = mk_bus(32'h100 + 32'(i * 4), vt[i].a, vt[i].b, 32'd0, vt[i].op, 3'd0, 1'b0, 1'b0, 1'b1, 5'd3);
      ID_to_EX_Valid = 1'b1;
      cyc();
      ID_to_EX_Valid = 1'b0;
      #1;
      chk($sformatf("alu%0d_valid", i), 32'(EX_to_MEM_Valid), 32'd1);
      chk($sformatf("alu%0d_result", i), EX_to_MEM_Bus[75:44], vt[i].exp);
      chk($sformatf("alu%0d_rdw", i), rdw_EX_Bus[31:0], vt[i].exp);
      chk($sformatf("alu%0d_memreq", i), 32'({MemRead, MemWrite}), 32'd0);
      cyc();
    end

    // SB at offset 3 with memory stalling three cycles
    ID_to_EX_Bus = mk_bus(32'h200, 32'h1000, 32'd3, 32'h000000AB, 4'd0, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0);
    ID_to_EX_Valid = 1'b1;
    cyc();
    ID_to_EX_Valid = 1'b0;
    #1;
    chk("sb_idle_memwrite", 32'(MemWrite), 32'd0);
    chk("sb_idle_valid", 32'(EX_to_MEM_Valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      Mem_Req_Ready = (k == 3);
      #1;
      chk($sformatf("sb_req%0d_memwrite", k), 32'(MemWrite), 32'd1);
      chk($sformatf("sb_req%0d_addr", k), Address, 32'h1000);
      chk($sformatf("sb_req%0d_data", k), Write_data, 32'hAB000000);
      chk($sformatf("sb_req%0d_strb", k), 32'(Write_strb), 32'b1000);
      chk($sformatf("sb_req%0d_valid", k), 32'(EX_to_MEM_Valid), (k == 3) ? 32'd1 : 32'd0);
    end
    cyc();
    Mem_Req_Ready = 1'b0;
    #1;
    chk("sb_after_memwrite", 32'(MemWrite), 32'd0);
    chk("sb_after_valid", 32'(EX_to_MEM_Valid), 32'd0);

    // LW held back by MEM_Allow_in low for two cycles
    MEM_Allow_in = 1'b0;
    ID_to_EX_Bus = mk_bus(32'h300, 32'h2000, 32'd0, 32'd0, 4'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd5);
    ID_to_EX_Valid = 1'b1;
    cyc();
    ID_to_EX_Valid = 1'b0;
    #1;
    chk("lw_blocked1_memread", 32'(MemRead), 32'd0);
    chk("lw_blocked1_allow", 32'(EX_Allow_in), 32'd0);
    cyc();
    chk("lw_blocked2_memread", 32'(MemRead), 32'd0);
    cyc();
    MEM_Allow_in = 1'b1;
    Mem_Req_Ready = 1'b1;
    #1;
    chk("lw_idle_memread", 32'(MemRead), 32'd0);
    cyc();
    chk("lw_req_memread", 32'(MemRead), 32'd1);
    chk("lw_req_addr", Address, 32'h2000);
    chk("lw_req_valid", 32'(EX_to_MEM_Valid), 32'd1);
    chk("lw_bus_load", 32'(EX_to_MEM_Bus[40]), 32'd1);
    chk("lw_bus_memwen", 32'(EX_to_MEM_Bus[38]), 32'd0);
    chk("lw_bus_wbwen", 32'(EX_to_MEM_Bus[37]), 32'd1);
    cyc();
    chk("lw_after_memread", 32'(MemRead), 32'd0);
    chk("lw_after_valid", 32'(EX_to_MEM_Valid), 32'd0);

    // Back-to-back SW then SH at offset 2, memory always ready
    ID_to_EX_Bus = mk_bus(32'h400, 32'h3000, 32'd0, 32'h11223344, 4'd0, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    ID_to_EX_Valid = 1'b1;
    cyc();
    ID_to_EX_Bus = mk_bus(32'h404, 32'h3000, 32'd2, 32'h00005566, 4'd0, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0);
    #1;
    for (int k = 0; k < 10; k++) begin
      if (MemWrite) begin
        strb_q.push_back(Write_strb);
        data_q.push_back(Write_data);
      end
      accepted = ID_to_EX_Valid && EX_Allow_in;
      cyc();
      if (accepted) ID_to_EX_Valid = 1'b0;
      #1;
    end
    chk("b2b_req_count", 32'(strb_q.size()), 32'd2);
    if (strb_q.size() == 2) begin
      chk("b2b_sw_strb", 32'(strb_q[0]), 32'b1111);
      chk("b2b_sw_data", data_q[0], 32'h11223344);
      chk("b2b_sh_strb", 32'(strb_q[1]), 32'b1100);
      chk("b2b_sh_data", data_q[1], 32'h55660000);
    end

    // Randomized non-memory traffic against an occupancy model
    occ = 1'b0; m_res = '0; m_pc = '0; m_wa = '0; m_wen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r_op = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
      if (r_op == 4'd11) r_op = 4'd0;
`endif
      r_a = $urandom; r_b = $urandom; r_pc = $urandom;
      r_wa = 5'($urandom); r_wen = 1'($urandom);
      ID_to_EX_Bus = mk_bus(r_pc, r_a, r_b, 32'($urandom), r_op, 3'($urandom), 1'b0, 1'b0, r_wen, r_wa);
      ID_to_EX_Valid = 1'($urandom);
      MEM_Allow_in = ($urandom_range(0, 3) != 0);
      #1;
      exp_allow = ~occ | MEM_Allow_in;
      chk("rand_allow", 32'(EX_Allow_in), 32'(exp_allow));
      chk("rand_valid", 32'(EX_to_MEM_Valid), 32'(occ));
      chk("rand_rdw_valid", 32'(rdw_EX_Bus[37]), 32'(occ & m_wen));
      if (occ) begin
        chk("rand_result", EX_to_MEM_Bus[75:44], m_res);
        chk("rand_pc", EX_to_MEM_Bus[31:0], m_pc);
        chk("rand_waddr", 32'(EX_to_MEM_Bus[36:32]), 32'(m_wa));
      end
      if (exp_allow) begin
        occ = ID_to_EX_Valid;
        if (ID_to_EX_Valid) begin
          m_res = ref_alu(r_op, r_a, r_b);
          m_pc = r_pc; m_wa = r_wa; m_wen = r_wen;
        end
      end
      cyc();
    end
    ID_to_EX_Valid = 1'b0;
    MEM_Allow_in = 1'b1;
    cyc(); cyc();

    // Reset while a store request is outstanding
    Mem_Req_Ready = 1'b0;
    ID_to_EX_Bus = mk_bus(32'h500, 32'h4000, 32'd0, 32'h0BADF00D, 4'd0, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    ID_to_EX_Valid = 1'b1;
    cyc();
    ID_to_EX_Valid = 1'b0;
    cyc();
    chk("rstreq_memwrite_before", 32'(MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq_memwrite_during", 32'(MemWrite), 32'd0);
    cyc();
    chk("rstreq_memwrite_after", 32'(MemWrite), 32'd0);
    chk("rstreq_valid_after", 32'(EX_to_MEM_Valid), 32'd0);
    chk("rstreq_allow_after", 32'(EX_Allow_in), 32'd1);
    rst = 1'b0;
    cyc();
    chk("rstreq_memwrite_released", 32'(MemWrite), 32'd0);

`ifdef EX_MUL_EN
    // Multiplier: 32 stall cycles, then the low product word
    ID_to_EX_Bus = mk_bus(32'h600, 32'h00010000, 32'h00010001, 32'd0, 4'd11, 3'd0, 1'b0, 1'b0, 1'b1, 5'd7);
    ID_to_EX_Valid = 1'b1;
    cyc();
    ID_to_EX_Valid = 1'b0;
    #1;
    stalls = 0;
    for (int k = 0; k < 40 && !EX_to_MEM_Valid; k++) begin
      if (!EX_Allow_in) stalls++;
      cyc();
    end
    chk("mul_stall_cycles", 32'(stalls), 32'd32);
    chk("mul_valid", 32'(EX_to_MEM_Valid), 32'd1);
    chk("mul_result", EX_to_MEM_Bus[75:44], 32'h00010000);
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V32 pipeline, sitting between ID and MEM.
- Latches the ID→EX bus and computes the ALU result.
- Issues the load/store request to data memory with a valid/ready handshake.
- Forwards a 108-bit EX→MEM bus; its field layout is fixed by the MEM stage. Also drives a 39-bit forwarding bus back to ID.

Parameters:
- ID_TO_EX_BUS_WD, 143, width of ID→EX bus.
- EX_TO_MEM_BUS_WD, 108, width of EX→MEM bus.
- RDW_BUS_WD, 39, width of forwarding bus.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- MEM_Allow_in  in  1  MEM stage can accept an instruction.
- EX_Allow_in  out  1  EX can accept from ID.
- ID_to_EX_Valid  in  1  ID output valid.
- ID_to_EX_Bus  in  143  {PC[142:111], op_a[110:79], op_b[78:47], RF_rdata2[46:15], alu_op[14:11], funct3[10:8], LOAD[7], STORE[6], WB_wen[5], RF_waddr[4:0]}.
- EX_to_MEM_Valid  out  1  EX output valid.
- EX_to_MEM_Bus  out  108  {RF_rdata2[107:76], Result[75:44], funct3[43:41], LOAD[40], STORE[39], MEM_wen[38], WB_wen[37], RF_waddr[36:32], PC[31:0]}; MEM_wen = STORE.
- Address  out  32  {Result[31:2],2'b00}.
- MemRead  out  1  load request.
- MemWrite  out  1  store request.
- Write_data  out  32  store data.
- Write_strb  out  4  byte enables.
- Mem_Req_Ready  in  1  memory accepts request this cycle.
- rdw_EX_Bus  out  39  {EX_Ready[38], WB_wen&EX_Valid[37], RF_waddr[36:32], Result[31:0]}.

Behaviour:
- Pipeline register and handshake:
  - EX_Valid register: reset 0; when EX_Allow_in, EX_Valid <= ID_to_EX_Valid.
  - Bus register loads on ID_to_EX_Valid & EX_Allow_in; it is not reset.
  - EX_Allow_in = ~EX_Valid | (EX_Ready & MEM_Allow_in).
  - EX_to_MEM_Valid = EX_Valid & EX_Ready.
- ALU, combinational on op_a/op_b by alu_op:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - 11 is MUL (see Optional Feature); 12-15 behave as ADD.
  - Shift amount is op_b[4:0]; all results are 32 bits and wrap.
- Memory request FSM, states IDLE, REQ, DONE; reset to IDLE:
  - IDLE→REQ when EX_Valid & (LOAD|STORE) & MEM_Allow_in.
  - In REQ: MemRead = LOAD, MemWrite = STORE.
  - REQ→DONE when Mem_Req_Ready. The request is accepted that cycle and EX_Ready is asserted the same cycle.
  - DONE→IDLE when the instruction leaves EX (EX_to_MEM_Valid & MEM_Allow_in). REQ→IDLE directly if it leaves in the acceptance cycle.
  - Request signals are 0 in IDLE and DONE; each instruction issues exactly one request.
  - Address, Write_data and Write_strb stay stable while in REQ.
  - Non-memory instructions: EX_Ready = 1, FSM stays in IDLE.
  - A request is never raised while MEM_Allow_in = 0. Once in REQ it is held until accepted, even if MEM_Allow_in drops.
- Store formatting, off = Result[1:0]:
  - Write_data = RF_rdata2 << (8*off).
  - Write_strb: SB (funct3[1:0]=00) → 4'b0001<<off; SH (01) → 4'b0011<<off; SW (10) → 4'b1111.
  - Misaligned accesses are not trapped; bits shifted out are dropped.
- Reset: rst mid-request forces IDLE and EX_Valid = 0 on the next edge. All request outputs, EX_to_MEM_Valid and rdw valid are 0 during and after reset.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: alu_op 11 runs an iterative shift-add multiplier returning the low 32 bits of op_a*op_b.
  - Starts the cycle after the instruction enters EX, runs 32 cycles; EX_Ready = 0 until it completes.
  - A counter 0..31 controls the multiplier; the result register holds until the instruction leaves.
  - rst aborts it.
- Not defined: alu_op 11 computes ADD in a single cycle; no multiplier logic is instantiated.

Test Plan:
- ADD op_a=5, op_b=0xFFFFFFFE, MEM_Allow_in=1 → EX_to_MEM_Valid 1 cycle after entry, Result=3, MemRead=MemWrite=0.
- SB RF_rdata2=0x000000AB, Result=0x1003, Mem_Req_Ready low for 3 cycles → MemWrite held 4 cycles, Address=0x1000, Write_data=0xAB000000, Write_strb=4'b1000; EX_to_MEM_Valid only in the accept cycle.
- LW Result=0x2000 while MEM_Allow_in=0 for 2 cycles → MemRead stays 0; then rises; Mem_Req_Ready=1 → one-cycle request, bus[40]=1, bus[38]=0.
- Back-to-back SW then SH off=2 with Mem_Req_Ready=1 → Write_strb 1111 then 1100; exactly one request per instruction.
- rst asserted while in REQ → next cycle MemWrite=0, EX_to_MEM_Valid=0, EX_Allow_in=1.
- (EX_MUL_EN) MUL 0x10000*0x10001 → Result=0x00010000 after 32 stall cycles; EX_Allow_in=0 throughout the stall.
